// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one
// Avalon-style memory master. The two ports take turns round-robin when they
// request together. One transaction is in flight at a time. Misaligned fetches
// never reach the bus and are answered with an error pulse instead.
module mem_arbiter (
   input  logic        clk,
   input  logic        reset_n,

   // instruction-fetch requester
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,

   // data requester
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ack,
   output logic [31:0] d_rdata,

   // memory-side master
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   input  logic        waitrequest,

   // status
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   // 1 = the most recent grant went to fetch, 0 = to data
   logic        last_fetch_reg;

   // Transaction captured at grant time. It stays frozen until the next grant,
   // so bus outputs cannot move while the slave stalls.
   logic        cur_fetch_reg;
   logic        lat_we_reg;
   logic [31:0] lat_addr_reg;
   logic [31:0] lat_wdata_reg;
   logic [3:0]  lat_be_reg;

   // Write completion is acknowledged in the cycle after the bus accepts it
   logic        wack_reg;

   // Last word returned to each port
   logic [31:0] if_rdata_reg;
   logic [31:0] d_rdata_reg;

   logic        grant_fetch;
   logic        grant_data;
   logic        misaligned;

   // Round-robin choice between the two requesters; grants only in IDLE
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (state_reg == IDLE) begin
         if (if_req && (!d_req || !last_fetch_reg)) begin
            grant_fetch = 1'b1;
         end else if (d_req) begin
            grant_data = 1'b1;
         end
      end
   end

   // A fetch whose byte address is not word aligned skips the bus entirely
   assign misaligned = cur_fetch_reg && (lat_addr_reg[1:0] != 2'b00);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (grant_fetch) begin
               state_next = FETCH;
            end else if (grant_data) begin
               state_next = DATA;
            end
         end
         FETCH: begin
            if (misaligned || !waitrequest) begin
               state_next = RESP;
            end
         end
         DATA: begin
            // Writes need no response phase; their ack is raised from wack_reg
            if (!waitrequest) begin
               state_next = lat_we_reg ? IDLE : RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture the granted requester's transaction and remember who won
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_fetch_reg <= 1'b0;
         cur_fetch_reg  <= 1'b0;
         lat_we_reg     <= 1'b0;
         lat_addr_reg   <= 32'h0;
         lat_wdata_reg  <= 32'h0;
         lat_be_reg     <= 4'h0;
      end else if (grant_fetch) begin
         last_fetch_reg <= 1'b1;
         cur_fetch_reg  <= 1'b1;
         lat_we_reg     <= 1'b0;
         lat_addr_reg   <= if_addr;
         lat_wdata_reg  <= 32'h0;
         lat_be_reg     <= 4'hF;
      end else if (grant_data) begin
         last_fetch_reg <= 1'b0;
         cur_fetch_reg  <= 1'b0;
         lat_we_reg     <= d_we;
         lat_addr_reg   <= d_addr;
         lat_wdata_reg  <= d_wdata;
         lat_be_reg     <= d_be;
      end
   end

   // Flag an accepted write so d_ack pulses in the following (IDLE) cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wack_reg <= 1'b0;
      end else begin
         wack_reg <= (state_reg == DATA) && lat_we_reg && !waitrequest;
      end
   end

   // Hold the last returned word per port; misaligned fetches leave it alone
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_rdata_reg <= 32'h0;
         d_rdata_reg  <= 32'h0;
      end else if (state_reg == RESP) begin
         if (cur_fetch_reg) begin
            if (!misaligned) begin
               if_rdata_reg <= readdata;
            end
         end else begin
            d_rdata_reg <= readdata;
         end
      end
   end

   // Output decode. In RESP the returned word is forwarded straight from
   // readdata so it is valid in the same cycle as the ack.
   always_comb begin
      read       = 1'b0;
      write      = 1'b0;
      address    = 32'h0;
      byteenable = 4'h0;
      writedata  = 32'h0;
      if_ack     = 1'b0;
      if_err     = 1'b0;
      d_ack      = wack_reg;
      if_rdata   = if_rdata_reg;
      d_rdata    = d_rdata_reg;
      busy       = (state_reg != IDLE);
      case (state_reg)
         FETCH: begin
            if (!misaligned) begin
               read       = 1'b1;
               address    = {lat_addr_reg[31:2], 2'b00};
               byteenable = lat_be_reg;
            end
         end
         DATA: begin
            read       = !lat_we_reg;
            write      = lat_we_reg;
            address    = {lat_addr_reg[31:2], 2'b00};
            byteenable = lat_be_reg;
            writedata  = lat_wdata_reg;
         end
         RESP: begin
            if (cur_fetch_reg) begin
               if (misaligned) begin
                  if_err = 1'b1;
               end else begin
                  if_ack   = 1'b1;
                  if_rdata = readdata;
               end
            end else begin
               d_ack   = 1'b1;
               d_rdata = readdata;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic. A
// transaction-level model predicts every output each cycle. Hand-computed
// literal checks in the directed scenarios pin the model itself.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic [31:0] d_wdata = 32'h0;
   logic [3:0]  d_be = 4'h0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata = 32'h0;
   logic        waitrequest = 1'b0;
   logic        busy;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .address(address), .read(read), .write(write), .byteenable(byteenable),
      .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
      .busy(busy)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- memory slave: readdata valid one cycle after an accepted read
   logic        acc_read = 1'b0;
   logic [31:0] rd_val = 32'h0;
   bit          rand_mode = 1'b0;

   always @(negedge clk) acc_read <= read && !waitrequest;

   always @(posedge clk) begin
      #1;
      readdata = (acc_read && !rand_mode) ? rd_val : $urandom;
   end

   // ---------------- transaction-level reference model
   logic        m_active, m_done, m_fetch, m_we, m_mis, m_wack, m_last_fetch;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
   logic [3:0]  m_be;
   wire         m_pick_fetch = if_req && (!d_req || !m_last_fetch);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active <= 1'b0; m_done <= 1'b0; m_fetch <= 1'b0; m_we <= 1'b0;
         m_mis <= 1'b0; m_wack <= 1'b0; m_last_fetch <= 1'b0;
         m_addr <= 32'h0; m_wdata <= 32'h0; m_be <= 4'h0;
         m_if_rdata <= 32'h0; m_d_rdata <= 32'h0;
      end else begin
         m_wack <= 1'b0;
         if (!m_active) begin
            if (if_req || d_req) begin
               m_active     <= 1'b1;
               m_done       <= 1'b0;
               m_fetch      <= m_pick_fetch;
               m_last_fetch <= m_pick_fetch;
               m_addr       <= m_pick_fetch ? if_addr : d_addr;
               m_we         <= m_pick_fetch ? 1'b0 : d_we;
               m_wdata      <= d_wdata;
               m_be         <= m_pick_fetch ? 4'hF : d_be;
               m_mis        <= m_pick_fetch && (if_addr[1:0] != 2'b00);
            end
         end else if (!m_done) begin
            if (m_mis || !waitrequest) begin
               if (!m_fetch && m_we) begin
                  m_active <= 1'b0;
                  m_wack   <= 1'b1;
               end else begin
                  m_done <= 1'b1;
               end
            end
         end else begin
            m_active <= 1'b0;
            if (m_fetch && !m_mis) m_if_rdata <= readdata;
            else if (!m_fetch) m_d_rdata <= readdata;
         end
      end
   end

   wire        e_bus    = m_active && !m_done && !m_mis;
   wire        e_read   = e_bus && (m_fetch || !m_we);
   wire        e_write  = e_bus && !m_fetch && m_we;
   wire        e_resp   = m_active && m_done;
   wire        e_if_ack = e_resp && m_fetch && !m_mis;
   wire        e_if_err = e_resp && m_mis;
   wire        e_d_ack  = (e_resp && !m_fetch) || m_wack;
   wire [31:0] e_if_rd  = e_if_ack ? readdata : m_if_rdata;
   wire [31:0] e_d_rd   = (e_resp && !m_fetch) ? readdata : m_d_rdata;

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_read", 32'(read), 32'h0);
         chk("rst_write", 32'(write), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_acks", {29'h0, if_ack, d_ack, if_err}, 32'h0);
         chk("rst_address", address, 32'h0);
         chk("rst_writedata", writedata, 32'h0);
         chk("rst_byteenable", 32'(byteenable), 32'h0);
         chk("rst_if_rdata", if_rdata, 32'h0);
         chk("rst_d_rdata", d_rdata, 32'h0);
      end else begin
         chk("read", 32'(read), 32'(e_read));
         chk("write", 32'(write), 32'(e_write));
         chk("busy", 32'(busy), 32'(m_active));
         chk("if_ack", 32'(if_ack), 32'(e_if_ack));
         chk("if_err", 32'(if_err), 32'(e_if_err));
         chk("d_ack", 32'(d_ack), 32'(e_d_ack));
         chk("if_rdata", if_rdata, e_if_rd);
         chk("d_rdata", d_rdata, e_d_rd);
         if (e_bus) begin
            chk("address", address, {m_addr[31:2], 2'b00});
            chk("byteenable", 32'(byteenable), 32'(m_be));
         end
         if (e_write) chk("writedata", writedata, m_wdata);
      end
   end

   // ---------------- stimulus
   byte ackq[$];
   byte exp_order[4];
   int  overlap;

   initial begin
      exp_order[0] = 8'h46; exp_order[1] = 8'h44;
      exp_order[2] = 8'h46; exp_order[3] = 8'h44;

      // reset
      cyc(); cyc();
      @(negedge clk);
      chk("lit_reset_busy", 32'(busy), 32'h0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // simultaneous requests from reset: F, D, F, D with no overlap
      if_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0; d_be = 4'hF;
      rd_val = 32'hCAFE_0001; waitrequest = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      overlap = 0;
      for (int i = 0; i < 11; i++) begin
         cyc();
         @(negedge clk);
         if (if_ack && d_ack) overlap++;
         if (if_ack) ackq.push_back(8'h46);
         if (d_ack) ackq.push_back(8'h44);
      end
      cyc();
      if_req = 1'b0; d_req = 1'b0;
      chk("lit_rr_acks", 32'(ackq.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("lit_rr_order%0d", i), (i < ackq.size()) ? 32'(ackq[i]) : 32'h0, 32'(exp_order[i]));
      chk("lit_rr_overlap", 32'(overlap), 32'h0);
      cyc();

      // single aligned fetch
      if_req = 1'b1; if_addr = 32'hBFC0_0000; rd_val = 32'h2402_0005;
      cyc();
      if_req = 1'b0;
      @(negedge clk);
      chk("lit_f_read", 32'(read), 32'h1);
      chk("lit_f_address", address, 32'hBFC0_0000);
      chk("lit_f_be", 32'(byteenable), 32'hF);
      cyc();
      @(negedge clk);
      chk("lit_f_ack", 32'(if_ack), 32'h1);
      chk("lit_f_rdata", if_rdata, 32'h2402_0005);
      cyc();
      @(negedge clk);
      chk("lit_f_ack_gone", 32'(if_ack), 32'h0);
      chk("lit_f_rdata_hold", if_rdata, 32'h2402_0005);
      cyc();

      // data write with three stall cycles
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1004; d_wdata = 32'hDEAD_BEEF;
      d_be = 4'b0011; waitrequest = 1'b1;
      cyc();
      d_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         waitrequest = (i < 3);
         @(negedge clk);
         chk($sformatf("lit_w_write%0d", i), 32'(write), 32'h1);
         chk($sformatf("lit_w_read%0d", i), 32'(read), 32'h0);
         chk($sformatf("lit_w_addr%0d", i), address, 32'h0000_1004);
         chk($sformatf("lit_w_data%0d", i), writedata, 32'hDEAD_BEEF);
         chk($sformatf("lit_w_be%0d", i), 32'(byteenable), 32'h3);
         chk($sformatf("lit_w_noack%0d", i), 32'(d_ack), 32'h0);
         cyc();
      end
      waitrequest = 1'b0;
      @(negedge clk);
      chk("lit_w_ack", 32'(d_ack), 32'h1);
      chk("lit_w_write_off", 32'(write), 32'h0);
      cyc();
      @(negedge clk);
      chk("lit_w_ack_gone", 32'(d_ack), 32'h0);
      cyc();

      // misaligned fetch
      if_req = 1'b1; if_addr = 32'h0000_0402;
      cyc();
      if_req = 1'b0;
      @(negedge clk);
      chk("lit_m_read1", 32'({read, write}), 32'h0);
      chk("lit_m_err1", 32'(if_err), 32'h0);
      cyc();
      @(negedge clk);
      chk("lit_m_err", 32'(if_err), 32'h1);
      chk("lit_m_noack", 32'(if_ack), 32'h0);
      chk("lit_m_read2", 32'({read, write}), 32'h0);
      chk("lit_m_rdata", if_rdata, 32'h2402_0005);
      cyc();
      @(negedge clk);
      chk("lit_m_err_gone", 32'(if_err), 32'h0);
      cyc();

      // reset during a stalled data read
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_be = 4'hF; waitrequest = 1'b1;
      cyc();
      d_req = 1'b0;
      @(negedge clk);
      chk("lit_r_read", 32'(read), 32'h1);
      cyc();
      #2;
      reset_n = 1'b0;
      #1;
      chk("lit_r_read_off", 32'(read), 32'h0);
      chk("lit_r_busy_off", 32'(busy), 32'h0);
      chk("lit_r_addr_off", address, 32'h0);
      cyc();
      reset_n = 1'b1; waitrequest = 1'b0;
      @(negedge clk);
      chk("lit_r_noack", 32'(d_ack), 32'h0);
      cyc();
      d_req = 1'b1; d_addr = 32'h0000_3008; rd_val = 32'h55AA_1234;
      cyc();
      d_req = 1'b0;
      @(negedge clk);
      chk("lit_r2_addr", address, 32'h0000_3008);
      cyc();
      @(negedge clk);
      chk("lit_r2_ack", 32'(d_ack), 32'h1);
      chk("lit_r2_rdata", d_rdata, 32'h55AA_1234);
      cyc();

      // data read with a single byte enable and unaligned address
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2003; d_be = 4'b1000; rd_val = 32'h1122_3344;
      cyc();
      d_req = 1'b0;
      @(negedge clk);
      chk("lit_b_addr", address, 32'h0000_2000);
      chk("lit_b_be", 32'(byteenable), 32'h8);
      chk("lit_b_read", 32'(read), 32'h1);
      cyc();
      @(negedge clk);
      chk("lit_b_ack", 32'(d_ack), 32'h1);
      chk("lit_b_rdata", d_rdata, 32'h1122_3344);
      cyc();

      // randomized traffic, including occasional asynchronous resets
      rand_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         reset_n     = ($urandom_range(0, 299) != 0);
         if_req      = ($urandom_range(0, 2) != 0);
         d_req       = ($urandom_range(0, 2) != 0);
         if_addr     = $urandom;
         if ($urandom_range(0, 5) != 0) if_addr[1:0] = 2'b00;
         d_we        = 1'($urandom_range(0, 1));
         d_addr      = $urandom;
         d_wdata     = $urandom;
         d_be        = 4'($urandom);
         waitrequest = ($urandom_range(0, 3) == 0);
         cyc();
      end
      reset_n = 1'b1; if_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
      repeat (6) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
